// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling ratio.
// Kept separate so the future uart_tx can reuse them.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick generator: one-cycle tick every DVSR clocks,
// asserted in the cycle where the counter holds DVSR-1.
module baud_tick_gen #(
  parameter int DVSR = 651
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;

  // next counter value, wrapping after DVSR-1
  always_comb begin
    if (count_r == LAST) begin
      count_next_s = '0;
    end else begin
      count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // counter and registered tick, aligned so tick is high while count_r == DVSR-1
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
      tick    <= (DVSR == 1) ? 1'b1 : 1'b0;
    end else begin
      count_r <= count_next_s;
      tick    <= (count_next_s == LAST);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver: 2-flop synchronizer, start-bit qualification,
// mid-bit sampling, stop-bit check with rx_done / frame_err strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DVSR    = 651,
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic            rx_done,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            busy
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [3:0]    S_MID   = 4'd7;
  localparam logic [3:0]    S_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    SB_LAST = 4'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

  logic            tick_s;
  logic            rx_meta_r, rx_sync_r;
  rx_state_t       state_r, state_next_s;
  logic [3:0]      s_r, s_next_s;
  logic [NW-1:0]   n_r, n_next_s;
  logic [DBIT-1:0] b_r, b_next_s;
  logic            done_next_s, err_next_s;

  baud_tick_gen #(.DVSR(DVSR)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  // next-state and datapath decisions, all based on the synchronized line
  always_comb begin
    state_next_s = state_r;
    s_next_s     = s_r;
    n_next_s     = n_r;
    b_next_s     = b_r;
    done_next_s  = 1'b0;
    err_next_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_sync_r) begin
          state_next_s = START;
          s_next_s     = 4'd0;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        // line must still be low at mid start bit, otherwise it was a glitch
        if (tick_s) begin
          if (s_r == S_MID) begin
            if (!rx_sync_r) begin
              state_next_s = DATA;
              s_next_s     = 4'd0;
              n_next_s     = '0;
            end else begin
              state_next_s = IDLE;
            end
          end else begin
            s_next_s = s_r + 4'd1;
          end
        end else begin
          s_next_s = s_r;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (s_r == S_LAST) begin
            s_next_s = 4'd0;
            b_next_s = {rx_sync_r, b_r[DBIT-1:1]};
            if (n_r == N_LAST) begin
              state_next_s = STOP;
            end else begin
              n_next_s = n_r + {{(NW-1){1'b0}}, 1'b1};
            end
          end else begin
            s_next_s = s_r + 4'd1;
          end
        end else begin
          s_next_s = s_r;
        end
      end
      STOP: begin
        // leaving at mid stop bit lets an immediately following start edge be caught
        if (tick_s) begin
          if (s_r == SB_LAST) begin
            if (rx_sync_r) begin
              done_next_s = 1'b1;
            end else begin
              err_next_s = 1'b1;
            end
            state_next_s = IDLE;
          end else begin
            s_next_s = s_r + 4'd1;
          end
        end else begin
          s_next_s = s_r;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // synchronizer, FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      state_r   <= IDLE;
      s_r       <= 4'd0;
      n_r       <= '0;
      b_r       <= '0;
      dout      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      state_r   <= state_next_s;
      s_r       <= s_next_s;
      n_r       <= n_next_s;
      b_r       <= b_next_s;
      if (done_next_s) begin
        dout <= b_r;
      end else begin
        dout <= dout;
      end
      rx_done   <= done_next_s;
      frame_err <= err_next_s;
      busy      <= (state_next_s != IDLE);
    end
  end

endmodule
